pll_retune_seq: RTL



---
 rtl/pll_cfg_pkg.sv | 20 ++
 rtl/sync_ff.sv | 21 ++
 rtl/pll_retune_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL retune sequencer: reconfig controller register map and FSM states.
package pll_cfg_pkg;

   localparam logic [5:0]  ADDR_MODE    = 6'h00;
   localparam logic [5:0]  ADDR_START   = 6'h02;
   localparam logic [5:0]  ADDR_M       = 6'h04;
   localparam logic [5:0]  ADDR_K       = 6'h07;
   localparam logic [31:0] MODE_WAITREQ = 32'd0;

   typedef enum logic [2:0] {
      IDLE,
      W_MODE,
      W_M,
      W_K,
      W_START,
      WAIT_LOCK,
      FIN
   } state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop single-bit synchroniser with asynchronous reset to 0.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   // Truncating the concatenation shifts d in at bit 0 for any depth, including 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sr <= '0;
      else       sr <= STAGES'({sr, d});
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_retune_seq.sv
// Retunes the fractional PLL through the reconfig controller's Avalon-MM port, then waits for a
// stable relock; reports done or a sticky timeout error.
module pll_retune_seq
   import pll_cfg_pkg::*;
#(
   parameter int LOCK_TIMEOUT = 2000000,
   parameter int LOCK_STABLE  = 1024,
   parameter int SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [31:0] k_frac,
   input  logic [15:0] m_cnt,
   input  logic        m_en,
   output logic        busy,
   output logic        done,
   output logic        error,
   input  logic        pll_locked,
   output logic [5:0]  mgmt_address,
   output logic        mgmt_write,
   output logic [31:0] mgmt_writedata,
   input  logic        mgmt_waitrequest
);

   localparam int TO_W = $clog2(LOCK_TIMEOUT) + 1;
   localparam int ST_W = $clog2(LOCK_STABLE) + 1;

   state_t            state, state_d, wr_next;
   logic              lock_s;
   logic [31:0]       k_sh, k_sh_d, wr_data, data_d;
   logic [15:0]       m_sh, m_sh_d;
   logic              me_sh, me_sh_d;
   logic              pending, pending_d, busy_d, done_d, error_d, wr_d, restart;
   logic [5:0]        wr_addr, addr_d;
   logic [TO_W-1:0]   to_cnt, to_cnt_d;
   logic [ST_W-1:0]   st_cnt, st_cnt_d;

   sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .clk   (clk),
      .reset (reset),
      .d     (pll_locked),
      .q     (lock_s)
   );

   always_comb begin
      state_d   = state;
      pending_d = pending;
      busy_d    = busy;
      done_d    = 1'b0;
      error_d   = error;
      wr_d      = mgmt_write;
      addr_d    = mgmt_address;
      data_d    = mgmt_writedata;
      k_sh_d    = k_sh;
      m_sh_d    = m_sh;
      me_sh_d   = me_sh;
      to_cnt_d  = to_cnt;
      st_cnt_d  = st_cnt;
      restart   = pending || req;

      wr_addr = ADDR_MODE;
      wr_data = MODE_WAITREQ;
      wr_next = me_sh ? W_M : W_K;
      case (state)
         W_M:     begin wr_addr = ADDR_M;     wr_data = {16'h0, m_sh}; wr_next = W_K;       end
         W_K:     begin wr_addr = ADDR_K;     wr_data = k_sh;          wr_next = W_START;   end
         W_START: begin wr_addr = ADDR_START; wr_data = 32'd1;         wr_next = WAIT_LOCK; end
         default: ;
      endcase

      // Last request wins; a request outside IDLE is remembered and replayed after this sequence.
      if (req) begin
         k_sh_d  = k_frac;
         m_sh_d  = m_cnt;
         me_sh_d = m_en;
         if (state != IDLE) pending_d = 1'b1;
      end

      case (state)
         IDLE: if (req) begin
            state_d = W_MODE;
            busy_d  = 1'b1;
            error_d = 1'b0;
         end
         W_MODE, W_M, W_K, W_START: begin
            if (!mgmt_write) begin
               wr_d   = 1'b1;
               addr_d = wr_addr;
               data_d = wr_data;
            end else if (!mgmt_waitrequest) begin
               wr_d     = 1'b0;
               state_d  = wr_next;
               to_cnt_d = '0;
               st_cnt_d = '0;
            end
         end
         WAIT_LOCK: begin
            st_cnt_d = !lock_s ? '0 : (st_cnt == '1) ? st_cnt : st_cnt + ST_W'(1);
            to_cnt_d = (to_cnt == '1) ? to_cnt : to_cnt + TO_W'(1);
            if (lock_s && st_cnt == ST_W'(LOCK_STABLE - 1)) begin
               state_d = FIN;
               done_d  = 1'b1;
            end else if (to_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
               error_d = 1'b1;
               if (restart) begin
                  state_d   = W_MODE;
                  pending_d = 1'b0;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end
         end
         FIN: begin
            if (restart) begin
               state_d   = W_MODE;
               pending_d = 1'b0;
            end else begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         pending        <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
         mgmt_write     <= 1'b0;
         mgmt_address   <= '0;
         mgmt_writedata <= '0;
         k_sh           <= '0;
         m_sh           <= '0;
         me_sh          <= 1'b0;
         to_cnt         <= '0;
         st_cnt         <= '0;
      end else begin
         state          <= state_d;
         pending        <= pending_d;
         busy           <= busy_d;
         done           <= done_d;
         error          <= error_d;
         mgmt_write     <= wr_d;
         mgmt_address   <= addr_d;
         mgmt_writedata <= data_d;
         k_sh           <= k_sh_d;
         m_sh           <= m_sh_d;
         me_sh          <= me_sh_d;
         to_cnt         <= to_cnt_d;
         st_cnt         <= st_cnt_d;
      end
   end

endmodule
